// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter and its return stack.
// Contents: command enum, fixed-priority command decode, stack-pointer width helper.
// No state, no latency; pure combinational definitions.
package pc_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } pc_cmd_e;

  // Stack pointer spans 0..depth inclusive, so it needs one more code than entries.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Fixed priority st > call > ret > inc > hold. Without a stack, call/ret
  // drop out entirely so inc still acts when they are asserted with it.
  function automatic pc_cmd_e pc_decode(input logic st, input logic call,
                                        input logic ret, input logic inc,
                                        input bit stack_en);
    if (st)                   return CMD_LOAD;
    else if (stack_en && call) return CMD_CALL;
    else if (stack_en && ret)  return CMD_RET;
    else if (inc)              return CMD_INC;
    else                       return CMD_HOLD;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses for the program counter.
// Latency: push/pop take effect on the next rising edge; top is combinational from registered sp.
// No backpressure: push while full and pop while empty are ignored (the caller flags the error).
// Ports: cl, rst_n (async active-low); push, pop, push_data in; top, full, empty out.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int SP_W  = sp_width(DEPTH)
) (
  input  logic             cl,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  top_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp - 1'b1;
  // When empty the index wraps; the value is don't-care because pop is refused.
  assign top     = mem[top_idx[AW-1:0]];

  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Contents need no reset: only entries below sp are ever read.
  always_ff @(posedge cl) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter.sv
// WIDTH-bit program counter with load, increment, wrap pulse and optional call/return stack.
// Latency: 1 cycle for every command; q, wrap and err are registered.
// No backpressure: a command is accepted every cycle; CALL while full / RET while empty hold q and pulse err.
// Ports: cl, rst_n (async active-low); st, call, ret, inc, d in; q, wrap, full, empty, err out.
// Build option: define PC_STACK_EN to include the return stack; otherwise call/ret are ignored.
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               DEPTH     = 8
) (
  input  logic             cl,
  input  logic             rst_n,
  input  logic             st,
  input  logic             call,
  input  logic             ret,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             full,
  output logic             empty,
  output logic             err
);

`ifdef PC_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  pc_cmd_e          cmd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             err_nxt;

  // One extra bit so the carry-out of q+STEP is the wrap indication.
  assign sum = {1'b0, q} + STEP_X;
  assign cmd = pc_decode(st, call, ret, inc, STACK_EN);

`ifdef PC_STACK_EN
  localparam int SP_W = sp_width(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] top;

  pc_return_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .SP_W (SP_W)
  ) u_stack (
    .cl       (cl),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_data(sum[WIDTH-1:0]),
    .top      (top),
    .full     (full),
    .empty    (empty)
  );
`else
  assign full  = 1'b0;
  assign empty = 1'b1;
`endif

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
`ifdef PC_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    case (cmd)
      CMD_LOAD: q_nxt = d;
      CMD_INC: begin
        q_nxt    = sum[WIDTH-1:0];
        wrap_nxt = sum[WIDTH];
      end
`ifdef PC_STACK_EN
      // The pushed return address is the wrapped sum; its carry is not a wrap event.
      CMD_CALL: begin
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          push  = 1'b1;
          q_nxt = d;
        end
      end
      CMD_RET: begin
        if (empty) begin
          err_nxt = 1'b1;
        end else begin
          pop   = 1'b1;
          q_nxt = top;
        end
      end
`endif
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed steps then random commands,
// every cycle compared against a queue-based reference model of the counter.
module tb_program_counter;

  localparam int               W     = 8;
  localparam int               STEP  = 1;
  localparam int               DEPTH = 2;
  localparam logic [W-1:0]     RVAL  = 8'hFD;
  localparam int               MOD   = 1 << W;

`ifdef PC_STACK_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic         cl = 1'b0;
  logic         rst_n;
  logic         st, call, ret, inc;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         wrap, full, empty, err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_q;
  int m_stk[$];
  bit m_wrap;
  bit m_err;

  program_counter #(
    .WIDTH    (W),
    .STEP     (STEP),
    .RESET_VAL(RVAL),
    .DEPTH    (DEPTH)
  ) dut (
    .cl   (cl),
    .rst_n(rst_n),
    .st   (st),
    .call (call),
    .ret  (ret),
    .inc  (inc),
    .d    (d),
    .q    (q),
    .wrap (wrap),
    .full (full),
    .empty(empty),
    .err  (err)
  );

  always #5 cl = ~cl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q    = int'(RVAL);
    m_stk  = {};
    m_wrap = 1'b0;
    m_err  = 1'b0;
  endtask

  // Spec rules applied directly to the sampled inputs.
  task automatic model_step(input bit s, input bit c, input bit r, input bit i, input int dv);
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (s) begin
      m_q = dv;
    end else if (SE && c) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stk.push_back((m_q + STEP) % MOD);
        m_q = dv;
      end
    end else if (SE && r) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_q = m_stk.pop_back();
    end else if (i) begin
      m_wrap = (m_q + STEP) >= MOD;
      m_q    = (m_q + STEP) % MOD;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},     32'(q),     32'(m_q));
    chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
    chk({tag, ".err"},   32'(err),   32'(m_err));
    chk({tag, ".full"},  32'(full),  32'(SE ? (m_stk.size() == DEPTH) : 1'b0));
    chk({tag, ".empty"}, 32'(empty), 32'(SE ? (m_stk.size() == 0) : 1'b1));
  endtask

  // Drive one command, let the edge sample it, then compare after the edge.
  task automatic do_cmd(input string tag, input bit s, input bit c, input bit r,
                        input bit i, input logic [W-1:0] dv);
    st = s; call = c; ret = r; inc = i; d = dv;
    @(posedge cl);
    model_step(s, c, r, i, int'(dv));
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    st = 0; call = 0; ret = 0; inc = 0; d = '0;
    model_reset();
    #12;
    chk("reset.q",     32'(q),     32'(RVAL));
    chk("reset.wrap",  32'(wrap),  32'd0);
    chk("reset.err",   32'(err),   32'd0);
    chk("reset.full",  32'(full),  32'd0);
    chk("reset.empty", 32'(empty), 32'd1);
    rst_n = 1'b1;

    // Increment across the top: FD, FE, FF, 00 with wrap on the last.
    do_cmd("inc1", 0, 0, 0, 1, 8'h00);
    do_cmd("inc2", 0, 0, 0, 1, 8'h00);
    do_cmd("inc3_wrap", 0, 0, 0, 1, 8'h00);
    chk("inc3_wrap.direct", 32'(wrap), 32'd1);
    do_cmd("hold", 0, 0, 0, 0, 8'h00);

    // Priority: st beats call and inc.
    do_cmd("prio", 1, 1, 0, 1, 8'h34);
    chk("prio.direct", 32'(q), 32'h34);

    // Nested calls up to full, overflow, returns, underflow.
    do_cmd("ld10",  1, 0, 0, 0, 8'h10);
    do_cmd("call40", 0, 1, 0, 0, 8'h40);
    do_cmd("call80", 0, 1, 0, 0, 8'h80);
    do_cmd("ovf",    0, 1, 0, 0, 8'hC0);
    do_cmd("ret1",   0, 0, 1, 0, 8'h00);
    do_cmd("ret2",   0, 0, 1, 0, 8'h00);
    do_cmd("unf",    0, 0, 1, 1, 8'h00);
    do_cmd("post_unf", 0, 0, 0, 0, 8'h00);

    // Call at the top of the range pushes the wrapped address without a wrap pulse.
    do_cmd("ldff",   1, 0, 0, 0, 8'hFF);
    do_cmd("callff", 0, 1, 0, 0, 8'h20);
    do_cmd("retff",  0, 0, 1, 0, 8'h00);

    // call+inc together: inc acts only when the stack is compiled out.
    do_cmd("ld5",     1, 0, 0, 0, 8'h05);
    do_cmd("callinc", 0, 1, 0, 1, 8'h60);
    do_cmd("ret_ci",  0, 0, 1, 0, 8'h00);

    // Asynchronous reset in the middle of a stacked state.
    do_cmd("pre_a", 0, 1, 0, 0, 8'h30);
    do_cmd("pre_b", 0, 1, 0, 0, 8'h50);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("arst.q",     32'(q),     32'(RVAL));
    chk("arst.full",  32'(full),  32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.err",   32'(err),   32'd0);
    rst_n = 1'b1;
    do_cmd("arst_ret", 0, 0, 1, 0, 8'h00);

    // Random command mix.
    for (int k = 0; k < 400; k++) begin
      do_cmd("rand",
             ($urandom_range(7) == 0),
             ($urandom_range(2) == 0),
             ($urandom_range(2) == 0),
             ($urandom_range(1) == 0),
             W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
